// File: rtl/fhe_arith_pkg.sv
// Shared definitions for the modular arithmetic datapaths: the op encoding and
// the default operand width used to pack lanes side by side.
package fhe_arith_pkg;

  localparam int unsigned DefaultBitWidth = 54;

  typedef enum logic [1:0] {
    OpAdd  = 2'd0,
    OpSub  = 2'd1,
    OpNeg  = 2'd2,
    OpPass = 2'd3
  } op_e;

endpackage

// File: rtl/mod_addsub_lane.sv
// One lane of the modular add/sub pipeline: S1 holds the raw result and its
// single-correction candidate, S2 holds the selected result. No flow control here.
module mod_addsub_lane
  import fhe_arith_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = DefaultBitWidth
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s1_en_i,
  input  logic                 s2_en_i,
  input  op_e                  op_i,
  input  logic [BIT_WIDTH-1:0] q_i,
  input  logic [BIT_WIDTH-1:0] a_i,
  input  logic [BIT_WIDTH-1:0] b_i,
  input  op_e                  s1_op_i,
  input  logic [BIT_WIDTH-1:0] s1_q_i,
  output logic [BIT_WIDTH-1:0] res_o,
  output logic                 err_o
);

  localparam int unsigned XW = BIT_WIDTH + 1;

  logic [XW-1:0] a_x, b_x, q_x, s1_q_x;
  logic [XW-1:0] raw_d, cand_d, raw_q, cand_q, sel;
  logic          err_d, s1_err_q, use_cand;
  logic [BIT_WIDTH-1:0] res_d, res_q;
  logic          err_q;

  assign a_x    = {1'b0, a_i};
  assign b_x    = {1'b0, b_i};
  assign q_x    = {1'b0, q_i};
  assign s1_q_x = {1'b0, s1_q_i};

  // NEG reuses the ADD-style correction: q-b reaches q only when b==0.
  always_comb begin
    raw_d  = '0;
    cand_d = '0;
    unique case (op_i)
      OpAdd: begin
        raw_d  = a_x + b_x;
        cand_d = raw_d - q_x;
      end
      OpSub: begin
        raw_d  = a_x - b_x;
        cand_d = raw_d + q_x;
      end
      OpNeg: begin
        raw_d  = q_x - b_x;
        cand_d = raw_d - q_x;
      end
      OpPass: begin
        raw_d  = a_x;
        cand_d = a_x;
      end
      default: ;
    endcase
    err_d = (a_i >= q_i) || (b_i >= q_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q    <= '0;
      cand_q   <= '0;
      s1_err_q <= 1'b0;
    end else if (s1_en_i) begin
      raw_q    <= raw_d;
      cand_q   <= cand_d;
      s1_err_q <= err_d;
    end
  end

  // For SUB the top bit of the extended difference is the borrow (a<b).
  always_comb begin
    use_cand = 1'b0;
    unique case (s1_op_i)
      OpAdd, OpNeg: use_cand = (raw_q >= s1_q_x);
      OpSub:        use_cand = raw_q[XW-1];
      OpPass:       use_cand = 1'b0;
      default:      use_cand = 1'b0;
    endcase
    sel   = use_cand ? cand_q : raw_q;
    res_d = sel[BIT_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
      err_q <= 1'b0;
    end else if (s2_en_i) begin
      res_q <= res_d;
      err_q <= s1_err_q;
    end
  end

  assign res_o = res_q;
  assign err_o = err_q;

endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage, multi-lane modular add/sub/neg/pass pipeline with valid/ready
// handshakes; all lanes of a beat share one op and one modulus.
module mod_addsub_pipe
  import fhe_arith_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = DefaultBitWidth,
  parameter int unsigned LANES     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [1:0]                 in_op,
  input  logic [BIT_WIDTH-1:0]       in_q,
  input  logic [LANES*BIT_WIDTH-1:0] in_a,
  input  logic [LANES*BIT_WIDTH-1:0] in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*BIT_WIDTH-1:0] out_res,
  output logic [LANES-1:0]           out_err
);

  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic s1_adv, s2_adv, s1_load, s2_load;
  op_e  in_op_e, s1_op_q;
  logic [BIT_WIDTH-1:0] s1_q_q;

  assign in_op_e = op_e'(in_op);

  // Ready never looks at in_valid; a stage moves when empty or when drained.
  always_comb begin
    s2_adv     = !s2_valid_q || out_ready;
    s1_adv     = !s1_valid_q || s2_adv;
    in_ready   = s1_adv && !rst;
    s1_load    = s1_adv && in_valid;
    s2_load    = s2_adv && s1_valid_q;
    s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_op_q    <= OpAdd;
      s1_q_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_load) begin
        s1_op_q <= in_op_e;
        s1_q_q  <= in_q;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mod_addsub_lane #(
      .BIT_WIDTH(BIT_WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .s1_en_i(s1_load),
      .s2_en_i(s2_load),
      .op_i   (in_op_e),
      .q_i    (in_q),
      .a_i    (in_a[i*BIT_WIDTH +: BIT_WIDTH]),
      .b_i    (in_b[i*BIT_WIDTH +: BIT_WIDTH]),
      .s1_op_i(s1_op_q),
      .s1_q_i (s1_q_q),
      .res_o  (out_res[i*BIT_WIDTH +: BIT_WIDTH]),
      .err_o  (out_err[i])
    );
  end

  assign out_valid = s2_valid_q;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Self-checking bench for mod_addsub_pipe: directed corner beats plus a random
// stream, all checked against a plain-arithmetic queue model.
module tb_mod_addsub_pipe;
  import fhe_arith_pkg::*;

  localparam int unsigned W  = 54;
  localparam int unsigned L  = 4;
  localparam int unsigned PW = W * L;
  localparam logic [W-1:0] Q   = 54'h3F_FFFF_FFFE_D001;
  localparam logic [W-1:0] QM1 = 54'h3F_FFFF_FFFE_D000;
  localparam logic [W-1:0] QM2 = 54'h3F_FFFF_FFFE_CFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [1:0]    in_op;
  logic [W-1:0]  in_q;
  logic [PW-1:0] in_a, in_b, out_res;
  logic [L-1:0]  out_err;

  always #5 clk = ~clk;

  mod_addsub_pipe #(
    .BIT_WIDTH(W),
    .LANES    (L)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_q     (in_q),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_res  (out_res),
    .out_err  (out_err)
  );

  typedef struct {
    logic [PW-1:0] res;
    logic [L-1:0]  err;
  } beat_t;

  beat_t         exp_q[$];
  int            n_vec = 0, n_fail = 0, cyc = 0, n_acc = 0, n_emit = 0, out_cyc = 0;
  logic          got_out = 1'b0, stall_prev = 1'b0;
  logic [PW-1:0] last_res, stall_res;
  logic [L-1:0]  last_err, stall_err;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_lane(input logic [1:0] op, input logic [W-1:0] q,
                                            input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] qq, aa, bb, r;
    qq = {10'b0, q};
    aa = {10'b0, a};
    bb = {10'b0, b};
    case (op)
      2'd0: begin
        r = aa + bb;
        if (r >= qq) r = r - qq;
      end
      2'd1: r = (aa >= bb) ? aa - bb : aa + qq - bb;
      2'd2: r = (bb == 0) ? 64'd0 : qq - bb;
      default: r = aa;
    endcase
    return r[W-1:0];
  endfunction

  // Lanes flagged as errors carry unchecked results, so their slot stays zero here.
  function automatic beat_t model(input logic [1:0] op, input logic [W-1:0] q,
                                  input logic [PW-1:0] a, input logic [PW-1:0] b);
    beat_t e;
    logic [W-1:0] ai, bi;
    e.res = '0;
    e.err = '0;
    for (int i = 0; i < L; i++) begin
      ai = a[i*W +: W];
      bi = b[i*W +: W];
      e.err[i] = (ai >= q) || (bi >= q);
      if (!e.err[i]) e.res[i*W +: W] = ref_lane(op, q, ai, bi);
    end
    return e;
  endfunction

  function automatic logic [PW-1:0] pack4(input logic [W-1:0] l0, input logic [W-1:0] l1,
                                          input logic [W-1:0] l2, input logic [W-1:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [PW-1:0] lane_mask(input logic [L-1:0] err);
    logic [PW-1:0] m;
    m = '0;
    for (int i = 0; i < L; i++) if (!err[i]) m[i*W +: W] = '1;
    return m;
  endfunction

  task automatic step(input logic v, input logic [1:0] op, input logic [W-1:0] q,
                      input logic [PW-1:0] a, input logic [PW-1:0] b, input logic ordy,
                      output logic acc);
    beat_t         e;
    logic [PW-1:0] m;
    in_valid  = v;
    in_op     = op;
    in_q      = q;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    #1;
    acc     = v && in_ready;
    got_out = 1'b0;
    if (stall_prev) begin
      check("hold_valid", PW'(out_valid), PW'(1'b1));
      check("hold_res", out_res, stall_res);
      check("hold_err", PW'(out_err), PW'(stall_err));
    end
    if (acc) begin
      exp_q.push_back(model(op, q, a, b));
      n_acc++;
    end
    if (out_valid && out_ready) begin
      got_out  = 1'b1;
      out_cyc  = cyc;
      last_res = out_res;
      last_err = out_err;
      n_emit++;
      if (exp_q.size() == 0) begin
        check("spurious_out", PW'(out_valid), '0);
      end else begin
        e = exp_q.pop_front();
        m = lane_mask(e.err);
        check("res", out_res & m, e.res & m);
        check("err", PW'(out_err), PW'(e.err));
      end
    end
    stall_prev = out_valid && !out_ready;
    stall_res  = out_res;
    stall_err  = out_err;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [1:0] op, input logic [W-1:0] q, input logic [PW-1:0] a,
                      input logic [PW-1:0] b, output int acc_cyc);
    logic acc;
    acc_cyc = -1;
    for (int k = 0; k < 50; k++) begin
      acc_cyc = cyc;
      step(1'b1, op, q, a, b, 1'b1, acc);
      if (acc) return;
    end
    check("send_timeout", PW'(in_ready), PW'(1'b1));
  endtask

  task automatic wait_out(input string name);
    logic acc;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 2'd0, Q, '0, '0, 1'b1, acc);
      if (got_out) return;
    end
    check({name, "_timeout"}, PW'(got_out), PW'(1'b1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int            ac, n, sent, acc0, em0, em_mark;
    logic          acc, v, ordy;
    logic [1:0]    op;
    logic [W-1:0]  q;
    logic [PW-1:0] a, b;
    beat_t         pin;

    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_q = Q; in_a = '0; in_b = '0; out_ready = 1'b0;
    #2;
    check("rst_out_valid", PW'(out_valid), '0);
    check("rst_in_ready", PW'(in_ready), '0);
    check("rst_out_res", out_res, '0);
    check("rst_out_err", PW'(out_err), '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("ready_after_rst", PW'(in_ready), PW'(1'b1));

    // Pin the model with hand-computed values.
    pin = model(2'd1, Q, pack4(0, 2, QM1, QM1), pack4(1, QM1, QM1, QM1));
    check("model_sub", pin.res, pack4(QM1, 54'd3, 0, 0));
    pin = model(2'd0, Q, pack4(QM1, 1, 0, 5), pack4(QM1, QM1, 0, 7));
    check("model_add", pin.res, pack4(QM2, 0, 0, 54'd12));

    send(2'd1, Q, pack4(0, 2, QM1, QM1), pack4(1, QM1, QM1, QM1), ac);
    wait_out("sub");
    check("sub_latency", PW'(out_cyc - ac), PW'(2));
    check("sub_res", last_res, pack4(QM1, 54'd3, 0, 0));

    send(2'd0, Q, pack4(QM1, 1, 0, 5), pack4(QM1, QM1, 0, 7), ac);
    wait_out("add");
    check("add_latency", PW'(out_cyc - ac), PW'(2));
    check("add_res", last_res, pack4(QM2, 0, 0, 54'd12));

    send(2'd2, Q, pack4(9, 9, 9, 9), pack4(0, 1, 2, QM1), ac);
    wait_out("neg");
    check("neg_res", last_res, pack4(0, QM1, QM2, 54'd1));

    send(2'd3, Q, pack4(5, 0, QM1, 123), pack4(7, 8, 9, 10), ac);
    wait_out("pass");
    check("pass_res", last_res, pack4(54'd5, 0, QM1, 54'd123));

    // Stall: out_ready low while three beats are offered.
    n = 0;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 2'd0, Q, pack4(W'(n), 1, 2, 3), pack4(10, W'(n), 20, 30), 1'b0, acc);
      if (acc) n++;
    end
    check("stall_accepted", PW'(n), PW'(2));
    check("stall_in_ready", PW'(in_ready), '0);
    for (int k = 0; k < 6; k++) step(1'b0, 2'd0, Q, '0, '0, 1'b1, acc);
    check("stall_drained", PW'(exp_q.size()), '0);

    send(2'd0, Q, pack4(1, 2, Q, 3), pack4(4, 5, 6, 7), ac);
    wait_out("err");
    check("err_flags", PW'(last_err), PW'(4'b0100));
    check("err_res", last_res & lane_mask(4'b0100), pack4(54'd5, 54'd7, 0, 54'd10));

    // Reset with two beats in flight.
    send(2'd0, Q, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), ac);
    send(2'd0, Q, pack4(2, 2, 2, 2), pack4(2, 2, 2, 2), ac);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("inflight_valid", PW'(out_valid), PW'(1'b1));
    rst = 1'b1;
    #1;
    check("midrst_out_valid", PW'(out_valid), '0);
    check("midrst_out_res", out_res, '0);
    check("midrst_in_ready", PW'(in_ready), '0);
    exp_q.delete();
    stall_prev = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_ready_after", PW'(in_ready), PW'(1'b1));
    em_mark = n_emit;
    for (int k = 0; k < 6; k++) step(1'b0, 2'd0, Q, '0, '0, 1'b1, acc);
    check("midrst_no_emit", PW'(n_emit - em_mark), '0);

    // Random stream.
    acc0 = n_acc;
    em0  = n_emit;
    sent = 0;
    for (int k = 0; k < 40000 && sent < 4096; k++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 9) < 7);
      op   = 2'($urandom_range(0, 3));
      q    = Q;
      if ($urandom_range(0, 3) == 0) begin
        q = W'({$urandom, $urandom});
        if (q < 2) q = Q;
      end
      for (int i = 0; i < L; i++) begin
        a[i*W +: W] = W'({$urandom, $urandom}) % q;
        b[i*W +: W] = W'({$urandom, $urandom}) % q;
      end
      step(v, op, q, a, b, ordy, acc);
      if (acc) sent++;
    end
    for (int k = 0; k < 10; k++) step(1'b0, 2'd0, Q, '0, '0, 1'b1, acc);
    check("rand_sent", PW'(n_acc - acc0), PW'(4096));
    check("rand_emitted", PW'(n_emit - em0), PW'(n_acc - acc0));
    check("rand_queue_empty", PW'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
